// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch/jump squash and a saturating stall-cycle counter.
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [1:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_read_a,
    input  logic [DATA_W-1:0] id_read_b,
    input  logic [DATA_W-1:0] id_imm,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_read_a,
    output logic [DATA_W-1:0] ex_read_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic src_hit;
    logic hz;
    logic bubble;

    // A load writing $zero produces nothing worth waiting for
    assign src_hit = (id_uses_rs & (ex_rt == id_rs))
                   | (id_uses_rt & (ex_rt == id_rt));
    assign hz = ex_valid & ex_mem_read & (ex_rt != '0)
              & id_valid & src_hit;
    assign stall      = hz & ~flush;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign bubble     = flush | stall | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_op     <= '0;
            ex_read_a     <= '0;
            ex_read_b     <= '0;
            ex_imm        <= '0;
        end else if (bubble) begin
            // Register numbers cleared so forwarding never matches a bubble
            ex_valid      <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_op     <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_src    <= id_alu_src;
            ex_reg_dst    <= id_reg_dst;
            ex_alu_op     <= id_alu_op;
            ex_read_a     <= id_read_a;
            ex_read_b     <= id_read_b;
            ex_imm        <= id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized and directed bench for id_ex_hazard_stage against a
// transaction-level model of the EX slot and stall counter.
module tb_id_ex_hazard_stage;

    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw, m2r, as, rdst;
        logic [1:0]  op;
        logic [31:0] ra, rb, imm;
        logic        urs, urt;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush;
    logic id_valid, id_uses_rs, id_uses_rt;
    logic [4:0] id_rs, id_rt, id_rd;
    logic id_reg_write, id_mem_read, id_mem_write;
    logic id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [1:0] id_alu_op;
    logic [31:0] id_read_a, id_read_b, id_imm;
    logic ex_valid;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic ex_reg_write, ex_mem_read, ex_mem_write;
    logic ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [1:0] ex_alu_op;
    logic [31:0] ex_read_a, ex_read_b, ex_imm;
    logic pc_write, ifid_write, stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [119:0] dut_vec;

    int errors = 0;
    int checks = 0;

    instr_t mex;
    instr_t cur;
    logic   cur_fl;
    int     mcnt;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_read_a(id_read_a),
        .id_read_b(id_read_b), .id_imm(id_imm),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_read_a(ex_read_a),
        .ex_read_b(ex_read_b), .ex_imm(ex_imm),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    assign dut_vec = {ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write,
                      ex_mem_read, ex_mem_write, ex_mem_to_reg,
                      ex_alu_src, ex_reg_dst, ex_alu_op,
                      ex_read_a, ex_read_b, ex_imm};

    function automatic logic [119:0] ex_vec(instr_t m);
        return {m.valid, m.rs, m.rt, m.rd, m.rw, m.mr, m.mw, m.m2r,
                m.as, m.rdst, m.op, m.ra, m.rb, m.imm};
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i.valid = ($urandom_range(0, 4) != 0);
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 31));
        i.urs = 1'($urandom);
        i.urt = 1'($urandom);
        i.rw = 1'($urandom);
        i.mr = ($urandom_range(0, 2) == 0);
        i.mw = 1'($urandom);
        i.m2r = 1'($urandom);
        i.as = 1'($urandom);
        i.rdst = 1'($urandom);
        i.op = 2'($urandom);
        i.ra = $urandom;
        i.rb = $urandom;
        i.imm = $urandom;
        return i;
    endfunction

    // lw rt, off(base)
    function automatic instr_t lw(int rt, int base);
        instr_t i = rnd_instr();
        i.valid = 1; i.rs = 5'(base); i.rt = 5'(rt); i.rd = 0;
        i.urs = 1; i.urt = 0; i.rw = 1; i.mr = 1; i.mw = 0;
        i.m2r = 1; i.as = 1; i.rdst = 0; i.op = 0;
        return i;
    endfunction

    // R-type rd = rs op rt
    function automatic instr_t rtype(int rd, int rs, int rt);
        instr_t i = rnd_instr();
        i.valid = 1; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        i.urs = 1; i.urt = 1; i.rw = 1; i.mr = 0; i.mw = 0;
        i.m2r = 0; i.as = 0; i.rdst = 1; i.op = 2;
        return i;
    endfunction

    // A load in EX blocks a consumer reading its (nonzero) target
    function automatic logic model_stall();
        logic dep;
        dep = (cur.urs && mex.rt == cur.rs) || (cur.urt && mex.rt == cur.rt);
        return mex.valid && mex.mr && mex.rt != 0 && cur.valid
               && dep && !cur_fl;
    endfunction

    task automatic drive(input instr_t i, input logic fl);
        cur = i;
        cur_fl = fl;
        flush = fl;
        id_valid = i.valid;
        id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_uses_rs = i.urs; id_uses_rt = i.urt;
        id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
        id_mem_to_reg = i.m2r; id_alu_src = i.as; id_reg_dst = i.rdst;
        id_alu_op = i.op;
        id_read_a = i.ra; id_read_b = i.rb; id_imm = i.imm;
    endtask

    task automatic tick();
        logic st;
        instr_t b;
        st = model_stall();
        @(posedge clk);
        if (!rst) begin
            if (st && mcnt < CMAX) mcnt++;
            if (cur_fl || st || !cur.valid) begin
                b = '0;
                b.ra = mex.ra; b.rb = mex.rb; b.imm = mex.imm;
                mex = b;
            end else begin
                mex = cur;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        mex = '0;
        mcnt = 0;
        repeat (3) begin
            drive(rnd_instr(), 1'($urandom));
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_ex got=%h want=0", dut_vec);
        end
        checks++;
        if ({stall_cnt, stall, pc_write, ifid_write} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_ctl got cnt=%0d stall=%b pcw=%b ifw=%b want 0 0 1 1",
                     stall_cnt, stall, pc_write, ifid_write);
        end
        rst = 0;
        drive(rtype(3, 1, 2), 0);
        tick();
        checks++;
        if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write}
            !== {1'b1, 5'd1, 5'd2, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_add got v=%b rs=%0d rt=%0d rd=%0d rw=%b want 1 1 2 3 1",
                     ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write);
        end
    endtask

    task automatic test_load_use();
        instr_t add;
        drive(lw(8, 9), 0);
        tick();
        add = rtype(10, 8, 11);
        drive(add, 0);
        #1;
        checks++;
        if ({stall, pc_write, ifid_write} !== 3'b100) begin
            errors++;
            $display("FAIL lu_stall got stall=%b pcw=%b ifw=%b want 1 0 0",
                     stall, pc_write, ifid_write);
        end
        tick();
        checks++;
        if ({ex_valid, ex_rt, stall_cnt} !== {1'b0, 5'd0, 2'd1}) begin
            errors++;
            $display("FAIL lu_bubble got v=%b rt=%0d cnt=%0d want 0 0 1",
                     ex_valid, ex_rt, stall_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_one_cycle got stall=%b want 0", stall);
        end
        tick();
        checks++;
        if ({ex_valid, ex_rs, stall_cnt} !== {1'b1, 5'd8, 2'd1}) begin
            errors++;
            $display("FAIL lu_capture got v=%b rs=%0d cnt=%0d want 1 8 1",
                     ex_valid, ex_rs, stall_cnt);
        end
        checks++;
        if (dut_vec !== ex_vec(mex)) begin
            errors++;
            $display("FAIL lu_model got=%h want=%h", dut_vec, ex_vec(mex));
        end
    endtask

    task automatic test_no_false_stall();
        instr_t addi;
        drive(lw(0, 9), 0);
        tick();
        drive(rtype(10, 0, 11), 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL nfs_zero got stall=%b want 0", stall);
        end
        tick();
        drive(lw(8, 9), 0);
        tick();
        addi = rtype(10, 12, 8);
        addi.urt = 0; addi.as = 1; addi.rdst = 0; addi.imm = 32'd4;
        drive(addi, 0);
        #1;
        checks++;
        if ({stall, pc_write} !== 2'b01) begin
            errors++;
            $display("FAIL nfs_uses_rt got stall=%b pcw=%b want 0 1",
                     stall, pc_write);
        end
        tick();
        checks++;
        if ({ex_valid, ex_rs, stall_cnt} !== {1'b1, 5'd12, 2'd1}) begin
            errors++;
            $display("FAIL nfs_addi got v=%b rs=%0d cnt=%0d want 1 12 1",
                     ex_valid, ex_rs, stall_cnt);
        end
    endtask

    task automatic test_flush();
        drive(lw(8, 9), 0);
        tick();
        drive(rtype(10, 8, 11), 1);
        #1;
        checks++;
        if ({stall, pc_write, ifid_write} !== 3'b011) begin
            errors++;
            $display("FAIL flush_comb got stall=%b pcw=%b ifw=%b want 0 1 1",
                     stall, pc_write, ifid_write);
        end
        tick();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_rt, stall_cnt}
            !== {3'b000, 5'd0, 2'd1}) begin
            errors++;
            $display("FAIL flush_bubble got v=%b rw=%b mr=%b rt=%0d cnt=%0d want 0 0 0 0 1",
                     ex_valid, ex_reg_write, ex_mem_read, ex_rt, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive(lw(5, 1), 0);
            tick();
            drive(rtype(6, 2, 5), 0);
            tick();
            tick();
            checks++;
            if (int'(stall_cnt) !== mcnt) begin
                errors++;
                $display("FAIL sat_step%0d got=%0d want=%0d",
                         k, stall_cnt, mcnt);
            end
        end
        checks++;
        if (stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold got=%0d want=3", stall_cnt);
        end
    endtask

    task automatic test_random();
        logic exp_st;
        for (int n = 0; n < 400; n++) begin
            drive(rnd_instr(), ($urandom_range(0, 9) == 0));
            #1;
            exp_st = model_stall();
            checks++;
            if ({stall, pc_write, ifid_write} !== {exp_st, !exp_st, !exp_st}) begin
                errors++;
                $display("FAIL rnd_comb%0d got %b%b%b want stall=%b",
                         n, stall, pc_write, ifid_write, exp_st);
            end
            tick();
            checks++;
            if (dut_vec !== ex_vec(mex) || int'(stall_cnt) !== mcnt) begin
                errors++;
                $display("FAIL rnd_ex%0d got=%h cnt=%0d want=%h cnt=%0d",
                         n, dut_vec, stall_cnt, ex_vec(mex), mcnt);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(lw(8, 9), 0);
        tick();
        drive(rtype(10, 8, 11), 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got stall=%b want 1", stall);
        end
        #1 rst = 1;
        #1;
        checks++;
        if (dut_vec !== '0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL ar_regs got=%h cnt=%0d want 0 0", dut_vec, stall_cnt);
        end
        checks++;
        if ({stall, pc_write, ifid_write} !== 3'b011) begin
            errors++;
            $display("FAIL ar_comb got stall=%b pcw=%b ifw=%b want 0 1 1",
                     stall, pc_write, ifid_write);
        end
        mex = '0;
        mcnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        tick();
        checks++;
        if ({ex_valid, ex_rs, ex_rd, stall_cnt} !== {1'b1, 5'd8, 5'd10, 2'd0}) begin
            errors++;
            $display("FAIL ar_replay got v=%b rs=%0d rd=%0d cnt=%0d want 1 8 10 0",
                     ex_valid, ex_rs, ex_rd, stall_cnt);
        end
    endtask

    initial begin
        drive(rnd_instr(), 0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core.
- Captures decoded ID fields each cycle and presents EX-stage register numbers and control to the forwarding unit and ALU.
- Stalls PC and IF/ID for exactly one cycle on a load-use dependency and inserts a bubble.
- Squashes on branch/jump flush. Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, width of register-file read data and sign-extended immediate
- REG_W, 5, register-number width
- CNT_W, 16, stall-counter width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  squash the instruction currently in ID (branch taken / jump)
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt, id_rd  input  REG_W each  decoded register numbers
- id_uses_rs, id_uses_rt  input  1 each  instruction reads rs / rt as a source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decoded control
- id_alu_op  input  2  ALU operation class
- id_read_a, id_read_b, id_imm  input  DATA_W each  register-file data and sign-extended immediate
- ex_valid  output  1  EX holds a real instruction
- ex_rs, ex_rt, ex_rd  output  REG_W each  registered register numbers (EXRegRs/EXRegRt feed forwarding)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst  output  1 each  registered control; ex_mem_read is the forwarding unit's load input
- ex_alu_op  output  2  registered ALU op
- ex_read_a, ex_read_b, ex_imm  output  DATA_W each  registered data
- pc_write  output  1  PC update enable (combinational)
- ifid_write  output  1  IF/ID register enable (combinational)
- stall  output  1  load-use hazard detected this cycle (combinational)
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst=1): every registered output is 0, including ex_valid, all ex_* fields and stall_cnt. Combinational outputs follow from the zeroed state: stall=0, pc_write=1, ifid_write=1.
- Hazard (combinational):
  - hz = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((id_uses_rs & ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
  - stall = hz & ~flush.
  - pc_write = ifid_write = ~stall.
- Register update, rising clk, in priority order:
  1. flush=1: bubble.
  2. else stall=1: bubble.
  3. else id_valid=0: bubble.
  4. else capture all id_* into ex_*, ex_valid=1.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op all forced to 0.
  - ex_rs, ex_rt, ex_rd forced to 0 so a bubble can never match in forwarding.
  - Data fields hold their previous value.
- Latency: one cycle ID->EX. A stall lasts exactly one cycle, because the bubble has ex_mem_read=0.
- A load followed by a dependent load stalls once. The second load then becomes the hazard source for its own consumer.
- Destination $zero (ex_rt=0) never stalls.
- Flush coincident with hz: flush wins. No stall, pc_write=1, bubble inserted, stall_cnt unchanged.
- stall_cnt increments by 1 on each rising edge where stall=1. It saturates at 2^CNT_W-1 with no wrap, and clears only on rst.
- rst asserted mid-stall: all outputs return to reset values immediately. The held ID instruction is re-presented by upstream.

Test Plan:
- Reset: assert rst with arbitrary inputs -> all ex_* = 0, stall_cnt = 0, pc_write=1, ifid_write=1. Deassert and present add $3,$1,$2 with valid=1 -> next cycle ex_rs=1, ex_rt=2, ex_rd=3, ex_reg_write=1, ex_valid=1.
- Load-use: lw $8,0($9) then add $10,$8,$11 (uses_rs) -> cycle after lw enters EX: stall=1, pc_write=0, ifid_write=0. Next edge: bubble (ex_valid=0, ex_rt=0). Following edge: add captured with ex_rs=8. stall_cnt=1.
- No false stall: lw $0,0($9) then add $10,$0,$11 -> stall never asserts. Also lw $8 then addi $10,$12,4 with uses_rt=0 and id_rt=8 -> no stall.
- Flush priority: lw $8 in EX, dependent add in ID, flush=1 -> stall=0, pc_write=1, bubble captured, stall_cnt unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use pairs -> stall_cnt reaches 3 and holds at 3.
- Async reset mid-stall: assert rst between edges while stall=1 -> outputs zero without waiting for clk, stall=0 immediately.
